// File: rtl/sc_note_arbiter.sv
// sc_note_arbiter
//   Round-robin scheduler between the per-lane note matchers and the score
//   accumulator. Each lane owns one holding slot; occupied slots are granted
//   one per clock, in rotating order, onto a single registered en/dt port.
//   Also sequences scoring run/pause/stop and keeps the consecutive-hit streak.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   start_i        pulse: IDLE->RUN, clears streak in any state
//   stop_i         pulse: any->IDLE, flushes all slots (wins over start_i)
//   pause_i        level: holds grants while high (RUN<->PAUSE)
//   hit_valid_i    per-lane matched-note request
//   hit_dt_i       per-lane timing margin, lane i at [i*DTW +: DTW]
//   hit_ready_o    per-lane slot empty and state not IDLE
//   miss_i         pulse: note passed unplayed, clears streak outside IDLE
//   score_en_o     one-cycle strobe for the granted event
//   score_dt_o     dt of the granted event (held between grants)
//   score_lane_o   lane of the granted event (held between grants)
//   streak_o       consecutive scoring hits, saturating
//   busy_o         any slot occupied
module sc_note_arbiter #(
   parameter int unsigned LANES  = 5,
   parameter int unsigned DTW    = 16,
   parameter int unsigned WINDOW = 100
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 pause_i,
   input  logic [LANES-1:0]     hit_valid_i,
   input  logic [LANES*DTW-1:0] hit_dt_i,
   output logic [LANES-1:0]     hit_ready_o,
   input  logic                 miss_i,
   output logic                 score_en_o,
   output logic [DTW-1:0]       score_dt_o,
   output logic [2:0]           score_lane_o,
   output logic [15:0]          streak_o,
   output logic                 busy_o
);

   localparam logic [DTW:0] WindowW = (DTW+1)'(WINDOW);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e           state_q, state_d;
   logic [LANES-1:0] full_q, full_d;
   logic [DTW-1:0]   dt_q [LANES];
   logic [DTW-1:0]   dt_d [LANES];
   logic [2:0]       ptr_q, ptr_d;
   logic             score_en_q, score_en_d;
   logic [DTW-1:0]   score_dt_q, score_dt_d;
   logic [2:0]       score_lane_q, score_lane_d;
   logic [15:0]      streak_q, streak_d;

   logic             grant_ok;
   logic             grant_found;
   logic [2:0]       grant_idx;
   logic             grant;

   // ---------------------------------------------------------------------
   // Run/pause/stop sequencing
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (stop_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start_i)  state_d = StRun;
            StRun:   if (pause_i)  state_d = StPause;
            StPause: if (!pause_i) state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
   end

   // Grants happen exactly on edges that land in RUN from RUN or PAUSE, so a
   // rising pause holds immediately and a falling pause grants on its edge.
   assign grant_ok = (state_q != StIdle) && !pause_i && !stop_i;

   // ---------------------------------------------------------------------
   // Rotating search for the first occupied slot at or after ptr_q
   // ---------------------------------------------------------------------
   always_comb begin
      logic [3:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         cand = 4'(ptr_q) + 4'(k);
         if (cand >= 4'(LANES)) cand = cand - 4'(LANES);
         if (!grant_found && full_q[cand[2:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[2:0];
         end
      end
   end

   assign grant = grant_ok && grant_found;

   // ---------------------------------------------------------------------
   // Slots, grant port, pointer and streak
   // ---------------------------------------------------------------------
   always_comb begin
      full_d       = full_q;
      dt_d         = dt_q;
      ptr_d        = ptr_q;
      score_en_d   = 1'b0;
      score_dt_d   = score_dt_q;
      score_lane_d = score_lane_q;
      streak_d     = streak_q;

      if (grant) begin
         full_d[grant_idx] = 1'b0;
         score_en_d        = 1'b1;
         score_dt_d        = dt_q[grant_idx];
         score_lane_d      = grant_idx;
         ptr_d = ({1'b0, grant_idx} + 4'd1 == 4'(LANES)) ? 3'd0 : grant_idx + 3'd1;
      end

      // A full slot is never ready, so a load never collides with its grant.
      for (int unsigned i = 0; i < LANES; i++) begin
         if (hit_valid_i[i] && hit_ready_o[i]) begin
            full_d[i] = 1'b1;
            dt_d[i]   = hit_dt_i[i*DTW +: DTW];
         end
      end

      if (stop_i) full_d = '0;

      if (start_i) begin
         streak_d = '0;
      end else if ((state_q != StIdle) && miss_i) begin
         streak_d = '0;
      end else if (grant) begin
         if ({1'b0, dt_q[grant_idx]} < WindowW) begin
            streak_d = (streak_q == 16'hFFFF) ? streak_q : streak_q + 16'd1;
         end else begin
            streak_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         full_q       <= '0;
         for (int unsigned i = 0; i < LANES; i++) dt_q[i] <= '0;
         ptr_q        <= '0;
         score_en_q   <= 1'b0;
         score_dt_q   <= '0;
         score_lane_q <= '0;
         streak_q     <= '0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         dt_q         <= dt_d;
         ptr_q        <= ptr_d;
         score_en_q   <= score_en_d;
         score_dt_q   <= score_dt_d;
         score_lane_q <= score_lane_d;
         streak_q     <= streak_d;
      end
   end

   assign hit_ready_o  = ~full_q & {LANES{state_q != StIdle}};
   assign busy_o       = |full_q;
   assign score_en_o   = score_en_q;
   assign score_dt_o   = score_dt_q;
   assign score_lane_o = score_lane_q;
   assign streak_o     = streak_q;

endmodule

// File: tb/tb_sc_note_arbiter.sv
// Bench for sc_note_arbiter: directed vector table, hand-written pause/stop,
// reset and saturation sequences, then random stimulus against a model.
module tb_sc_note_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, pause, miss;
   logic [4:0]  hit_valid;
   logic [79:0] hit_dt;
   logic [4:0]  hit_ready;
   logic        score_en;
   logic [15:0] score_dt;
   logic [2:0]  score_lane;
   logic [15:0] streak;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sc_note_arbiter #(.LANES(5), .DTW(16), .WINDOW(100)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .stop_i       (stop),
      .pause_i      (pause),
      .hit_valid_i  (hit_valid),
      .hit_dt_i     (hit_dt),
      .hit_ready_o  (hit_ready),
      .miss_i       (miss),
      .score_en_o   (score_en),
      .score_dt_o   (score_dt),
      .score_lane_o (score_lane),
      .streak_o     (streak),
      .busy_o       (busy)
   );

   // ------------------------------------------------------------------
   // Reference model: mode 0=idle 1=run 2=pause; slots as plain arrays.
   // ------------------------------------------------------------------
   int m_mode;
   bit m_full [5];
   int m_dtv  [5];
   int m_ptr, m_sdt, m_slane, m_streak;
   bit m_en;

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_sdt = 0; m_slane = 0; m_streak = 0; m_en = 0;
      for (int i = 0; i < 5; i++) begin m_full[i] = 0; m_dtv[i] = 0; end
   endtask

   task automatic model_step();
      int  g;
      bit  rdy [5];
      g = -1;
      for (int i = 0; i < 5; i++) rdy[i] = !m_full[i] && (m_mode != 0);
      if (m_mode != 0 && !pause && !stop) begin
         for (int k = 0; k < 5; k++) begin
            if (g < 0 && m_full[(m_ptr + k) % 5]) g = (m_ptr + k) % 5;
         end
      end
      if (start)                     m_streak = 0;
      else if (m_mode != 0 && miss)  m_streak = 0;
      else if (g >= 0)               m_streak = (m_dtv[g] < 100) ?
                                        ((m_streak >= 65535) ? 65535 : m_streak + 1) : 0;
      m_en = (g >= 0);
      if (g >= 0) begin
         m_sdt = m_dtv[g]; m_slane = g; m_ptr = (g + 1) % 5; m_full[g] = 0;
      end
      for (int i = 0; i < 5; i++) begin
         if (hit_valid[i] && rdy[i]) begin m_full[i] = 1; m_dtv[i] = int'(hit_dt[i*16 +: 16]); end
      end
      if (stop) begin
         for (int i = 0; i < 5; i++) m_full[i] = 0;
         m_mode = 0;
      end else if (m_mode == 0 && start) m_mode = 1;
      else if (m_mode == 1 && pause)     m_mode = 2;
      else if (m_mode == 2 && !pause)    m_mode = 1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_model();
      logic [4:0] er;
      logic       eb;
      er = '0; eb = 1'b0;
      for (int i = 0; i < 5; i++) begin
         er[i] = !m_full[i] && (m_mode != 0);
         eb    = eb | m_full[i];
      end
      check("model score_en",   {31'd0, score_en},   {31'd0, m_en});
      check("model score_dt",   {16'd0, score_dt},   32'(m_sdt));
      check("model score_lane", {29'd0, score_lane}, 32'(m_slane));
      check("model streak",     {16'd0, streak},     32'(m_streak));
      check("model busy",       {31'd0, busy},       {31'd0, eb});
      check("model hit_ready",  {27'd0, hit_ready},  {27'd0, er});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; pause = 0; miss = 0; hit_valid = '0; hit_dt = '0;
   endtask

   function automatic logic [79:0] dl(input int lane, input int val);
      logic [79:0] r;
      r = '0;
      r[lane*16 +: 16] = 16'(val);
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      logic        st, sp, ps, ms;
      logic [4:0]  hv;
      logic [79:0] dts;
      logic        e_en;
      logic [2:0]  e_ln;
      logic [15:0] e_dt;
      logic [15:0] e_sk;
      logic        e_bz;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic ms, input logic [4:0] hv,
                               input logic [79:0] dts, input logic en, input int ln,
                               input int dt, input int sk, input logic bz);
      vec_t v;
      v.st = st; v.sp = 1'b0; v.ps = 1'b0; v.ms = ms; v.hv = hv; v.dts = dts;
      v.e_en = en; v.e_ln = 3'(ln); v.e_dt = 16'(dt); v.e_sk = 16'(sk); v.e_bz = bz;
      return v;
   endfunction

   vec_t tbl [32];

   initial begin
      // Rows from IDLE, ptr=0: single hit, round robin, streak, miss, back-to-back.
      tbl[0]  = mk(1, 0, 5'b00000, '0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 5'b01000, dl(3, 7), 0, 0, 0, 0, 1);
      tbl[2]  = mk(0, 0, 5'b00000, '0, 1, 3, 7, 1, 0);
      tbl[3]  = mk(0, 0, 5'b00000, '0, 0, 3, 7, 1, 0);
      tbl[4]  = mk(0, 0, 5'b10000, dl(4, 10), 0, 3, 7, 1, 1);
      tbl[5]  = mk(0, 0, 5'b00000, '0, 1, 4, 10, 2, 0);
      tbl[6]  = mk(0, 0, 5'b10110, dl(1, 5) | dl(2, 30) | dl(4, 60), 0, 4, 10, 2, 1);
      tbl[7]  = mk(0, 0, 5'b00000, '0, 1, 1, 5, 3, 1);
      tbl[8]  = mk(0, 0, 5'b00000, '0, 1, 2, 30, 4, 1);
      tbl[9]  = mk(0, 0, 5'b00000, '0, 1, 4, 60, 5, 0);
      tbl[10] = mk(0, 0, 5'b00010, dl(1, 8), 0, 4, 60, 5, 1);
      tbl[11] = mk(0, 0, 5'b00000, '0, 1, 1, 8, 6, 0);
      tbl[12] = mk(0, 0, 5'b00111, dl(0, 11) | dl(1, 12) | dl(2, 13), 0, 1, 8, 6, 1);
      tbl[13] = mk(0, 0, 5'b00000, '0, 1, 2, 13, 7, 1);
      tbl[14] = mk(0, 0, 5'b00000, '0, 1, 0, 11, 8, 1);
      tbl[15] = mk(0, 0, 5'b00000, '0, 1, 1, 12, 9, 0);
      tbl[16] = mk(1, 0, 5'b00000, '0, 0, 1, 12, 0, 0);
      tbl[17] = mk(0, 0, 5'b00100, dl(2, 3), 0, 1, 12, 0, 1);
      tbl[18] = mk(0, 0, 5'b00000, '0, 1, 2, 3, 1, 0);
      tbl[19] = mk(0, 0, 5'b01000, dl(3, 99), 0, 2, 3, 1, 1);
      tbl[20] = mk(0, 0, 5'b00000, '0, 1, 3, 99, 2, 0);
      tbl[21] = mk(0, 0, 5'b10000, dl(4, 100), 0, 3, 99, 2, 1);
      tbl[22] = mk(0, 0, 5'b00000, '0, 1, 4, 100, 0, 0);
      tbl[23] = mk(0, 0, 5'b00001, dl(0, 4), 0, 4, 100, 0, 1);
      tbl[24] = mk(0, 1, 5'b00000, '0, 1, 0, 4, 0, 0);
      tbl[25] = mk(0, 0, 5'b00100, dl(2, 20), 0, 0, 4, 0, 1);
      tbl[26] = mk(0, 0, 5'b00100, dl(2, 20), 1, 2, 20, 1, 0);
      tbl[27] = mk(0, 0, 5'b00100, dl(2, 20), 0, 2, 20, 1, 1);
      tbl[28] = mk(0, 0, 5'b00100, dl(2, 20), 1, 2, 20, 2, 0);
      tbl[29] = mk(0, 0, 5'b00100, dl(2, 20), 0, 2, 20, 2, 1);
      tbl[30] = mk(0, 0, 5'b00100, dl(2, 20), 1, 2, 20, 3, 0);
      tbl[31] = mk(0, 0, 5'b00000, '0, 0, 2, 20, 3, 0);
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #3;
      check("reset score_en",  {31'd0, score_en}, 32'd0);
      check("reset streak",    {16'd0, streak},   32'd0);
      check("reset busy",      {31'd0, busy},     32'd0);
      check("reset hit_ready", {27'd0, hit_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Make outputs non-zero, park lanes 0 and 2 under pause, then reset mid-cycle.
      start = 1; tick(); start = 0;
      hit_valid = 5'b01000; hit_dt = dl(3, 7); tick();
      hit_valid = '0; tick();
      pause = 1; hit_valid = 5'b00101; hit_dt = dl(0, 9) | dl(2, 9); tick();
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      hit_valid = '0;
      #2 rst = 1'b1;
      #1;
      check("async score_en",   {31'd0, score_en},   32'd0);
      check("async score_dt",   {16'd0, score_dt},   32'd0);
      check("async score_lane", {29'd0, score_lane}, 32'd0);
      check("async streak",     {16'd0, streak},     32'd0);
      check("async busy",       {31'd0, busy},       32'd0);
      check("async hit_ready",  {27'd0, hit_ready},  32'd0);
      model_reset();
      pause = 0;
      @(negedge clk);
      rst = 1'b0;

      // Requests in IDLE are never accepted.
      hit_valid = 5'b11111; hit_dt = {5{16'd5}};
      #1 check("idle hit_ready", {27'd0, hit_ready}, 32'd0);
      tick(); tick();
      idle_inputs();

      // Vector table.
      for (int r = 0; r < 32; r++) begin
         start = tbl[r].st; stop = tbl[r].sp; pause = tbl[r].ps; miss = tbl[r].ms;
         hit_valid = tbl[r].hv; hit_dt = tbl[r].dts;
         tick();
         check($sformatf("row%0d score_en", r),   {31'd0, score_en},   {31'd0, tbl[r].e_en});
         check($sformatf("row%0d score_lane", r), {29'd0, score_lane}, {29'd0, tbl[r].e_ln});
         check($sformatf("row%0d score_dt", r),   {16'd0, score_dt},   {16'd0, tbl[r].e_dt});
         check($sformatf("row%0d streak", r),     {16'd0, streak},     {16'd0, tbl[r].e_sk});
         check($sformatf("row%0d busy", r),       {31'd0, busy},       {31'd0, tbl[r].e_bz});
      end
      idle_inputs();

      // Pause holds grants; dropping pause grants on that edge.
      pause = 1; hit_valid = 5'b00001; hit_dt = dl(0, 2); tick();
      check("pause busy", {31'd0, busy}, 32'd1);
      check("pause no en", {31'd0, score_en}, 32'd0);
      hit_valid = '0; tick();
      check("pause hold en", {31'd0, score_en}, 32'd0);
      pause = 0; tick();
      check("unpause en",   {31'd0, score_en},   32'd1);
      check("unpause lane", {29'd0, score_lane}, 32'd0);
      check("unpause dt",   {16'd0, score_dt},   32'd2);
      check("unpause streak", {16'd0, streak},   32'd4);

      // Stop with three slots full: flush, no grant, streak kept.
      pause = 1; hit_valid = 5'b11010; hit_dt = dl(1, 50) | dl(3, 50) | dl(4, 50); tick();
      check("stop pre busy", {31'd0, busy}, 32'd1);
      pause = 0; stop = 1; hit_valid = '0; tick();
      check("stop en",     {31'd0, score_en}, 32'd0);
      check("stop busy",   {31'd0, busy},     32'd0);
      check("stop streak", {16'd0, streak},   32'd4);
      stop = 0; tick();
      check("after stop en", {31'd0, score_en}, 32'd0);
      start = 1; tick(); start = 0;
      check("restart streak", {16'd0, streak}, 32'd0);

      // Saturation: preload streak to all-ones, then two dt=1 hits.
      hit_valid = 5'b00010; hit_dt = dl(1, 1); tick();
      hit_valid = '0;
      force dut.streak_q = 16'hFFFF;
      m_streak = 65535;
      tick();
      release dut.streak_q;
      hit_valid = 5'b00100; hit_dt = dl(2, 1); tick();
      hit_valid = '0; tick();
      check("saturate en",     {31'd0, score_en}, 32'd1);
      check("saturate streak", {16'd0, streak},   32'h0000FFFF);
      idle_inputs();

      // Random stimulus against the model.
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 39) == 0);
         stop  = ($urandom_range(0, 79) == 0);
         miss  = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 14) == 0) pause = ~pause;
         hit_valid = 5'($urandom) & 5'($urandom);
         for (int i = 0; i < 5; i++) hit_dt[i*16 +: 16] = 16'($urandom_range(0, 150));
         tick();
      end
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
